// File: rtl/dnn_result_readout_if.sv
// Bus between the inference-core wrapper and dnn_result_readout: capture strobe,
// flattened scores, readout index and the readout/argmax result fields.
interface dnn_result_readout_if #(
   parameter int DATA_WIDTH  = 11,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_WIDTH   = 4
);
   logic                              clear;
   logic                              core_done;
   logic [NUM_CLASSES*DATA_WIDTH-1:0] core_out;
   logic [IDX_WIDTH-1:0]              out_idx;
   logic signed [DATA_WIDTH-1:0]      out;
   logic                              idx_err;
   logic                              busy;
   logic                              pred_valid;
   logic [IDX_WIDTH-1:0]              pred_class;
   logic signed [DATA_WIDTH-1:0]      pred_score;
   logic signed [DATA_WIDTH:0]        pred_margin;

   modport master (
      output clear, core_done, core_out, out_idx,
      input  out, idx_err, busy, pred_valid, pred_class, pred_score, pred_margin
   );

   modport slave (
      input  clear, core_done, core_out, out_idx,
      output out, idx_err, busy, pred_valid, pred_class, pred_score, pred_margin
   );
endinterface

// File: rtl/dnn_result_readout.sv
// Snapshots class scores on core_done, runs a one-class-per-cycle signed argmax and
// serves a registered indexed readout. DNN_READOUT_MARGIN_EN adds best/second-best margin.
module dnn_result_readout #(
   parameter int DATA_WIDTH  = 11,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   dnn_result_readout_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
   localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);

   state_t                                 state_q, state_d;
   logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] snap_q, snap_d;
   logic signed [DATA_WIDTH-1:0]           best_q, best_d;
   logic [IDX_WIDTH-1:0]                   best_idx_q, best_idx_d;
   logic [IDX_WIDTH-1:0]                   scan_idx_q, scan_idx_d;
   logic signed [DATA_WIDTH-1:0]           out_q, out_d;
   logic                                   idx_err_q, idx_err_d;
   logic signed [DATA_WIDTH-1:0]           cand;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // clear beats core_done; core_done restarts the scan from any state
   always_comb begin
      state_d = state_q;
      if (bus.clear)                              state_d = IDLE;
      else if (bus.core_done)                     state_d = SCAN;
      else if (state_q == SCAN && scan_idx_q == LAST_IDX) state_d = DONE;
   end

   always_comb begin
      bus.busy       = (state_q == SCAN);
      bus.pred_valid = (state_q == DONE);
   end

   always_comb begin
      cand = '0;
      for (int k = 0; k < NUM_CLASSES; k++)
         if (scan_idx_q == IDX_WIDTH'(k)) cand = snap_q[k];
   end

   // Readout samples the current snapshot, so an index presented with core_done sees old data
   always_comb begin
      out_d     = '0;
      idx_err_d = ({1'b0, bus.out_idx} >= (IDX_WIDTH + 1)'(NUM_CLASSES));
      for (int k = 0; k < NUM_CLASSES; k++)
         if (bus.out_idx == IDX_WIDTH'(k)) out_d = snap_q[k];
   end

   always_comb begin
      snap_d     = snap_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      scan_idx_d = scan_idx_q;
      if (bus.clear) begin
         snap_d     = '0;
         best_d     = '0;
         best_idx_d = '0;
         scan_idx_d = '0;
      end else if (bus.core_done) begin
         snap_d     = bus.core_out;
         best_d     = bus.core_out[DATA_WIDTH-1:0];
         best_idx_d = '0;
         scan_idx_d = ONE_IDX;
      end else if (state_q == SCAN) begin
         if (cand > best_q) begin
            best_d     = cand;
            best_idx_d = scan_idx_q;
         end
         scan_idx_d = scan_idx_q + ONE_IDX;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q     <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         scan_idx_q <= '0;
         out_q      <= '0;
         idx_err_q  <= 1'b0;
      end else begin
         snap_q     <= snap_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         scan_idx_q <= scan_idx_d;
         out_q      <= out_d;
         idx_err_q  <= idx_err_d;
      end
   end

   assign bus.out        = out_q;
   assign bus.idx_err    = idx_err_q;
   assign bus.pred_class = best_idx_q;
   assign bus.pred_score = best_q;

`ifdef DNN_READOUT_MARGIN_EN
   localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [DATA_WIDTH-1:0] sec_q, sec_d;

   always_comb begin
      sec_d = sec_q;
      if (bus.clear)              sec_d = '0;
      else if (bus.core_done)     sec_d = MOST_NEG;
      else if (state_q == SCAN) begin
         if (cand > best_q)       sec_d = best_q;
         else if (cand > sec_q)   sec_d = cand;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sec_q <= '0;
      else     sec_q <= sec_d;
   end

   // One extra bit of headroom: max - min of DATA_WIDTH signed values always fits
   assign bus.pred_margin = {best_q[DATA_WIDTH-1], best_q} - {sec_q[DATA_WIDTH-1], sec_q};
`else
   assign bus.pred_margin = '0;
`endif
endmodule

// File: tb/tb_dnn_result_readout.sv
// Directed bench for dnn_result_readout: argmax/readout model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_dnn_result_readout;
   localparam int DW = 11;
   localparam int NC = 10;
   localparam int IW = 4;
`ifdef DNN_READOUT_MARGIN_EN
   localparam bit MEN = 1'b1;
`else
   localparam bit MEN = 1'b0;
`endif

   typedef int arr_t[NC];
   typedef struct {int cls; int score; int margin;} res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dnn_result_readout_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) bus ();
   dnn_result_readout #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NC*DW-1:0] pack(input arr_t s);
      logic [NC*DW-1:0] v;
      v = '0;
      for (int k = 0; k < NC; k++) v[k*DW +: DW] = DW'(s[k]);
      return v;
   endfunction

   function automatic arr_t unpack(input logic [NC*DW-1:0] v);
      arr_t s;
      for (int k = 0; k < NC; k++) s[k] = $signed(v[k*DW +: DW]);
      return s;
   endfunction

   // Lowest index of the maximum; margin against the best of the remaining classes
   function automatic res_t argmax(input arr_t s);
      res_t r;
      int   sec;
      r.cls = 0;
      r.score = s[0];
      for (int k = 1; k < NC; k++)
         if (s[k] > r.score) begin r.score = s[k]; r.cls = k; end
      sec = -(1 << 30);
      for (int k = 0; k < NC; k++)
         if (k != r.cls && s[k] > sec) sec = s[k];
      r.margin = MEN ? (r.score - sec) : 0;
      return r;
   endfunction

   // Model: m_cnt = cycles since capture (0 idle, NC means result ready)
   arr_t m_snap;
   int   m_cnt;
   res_t m_res;
   int   m_out;
   int   m_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_snap <= '{default: 0};
         m_cnt  <= 0;
         m_res  <= '{0, 0, 0};
         m_out  <= 0;
         m_err  <= 0;
      end else begin
         m_out <= (bus.out_idx < NC) ? m_snap[bus.out_idx] : 0;
         m_err <= (bus.out_idx >= NC) ? 1 : 0;
         if (bus.clear) begin
            m_snap <= '{default: 0};
            m_cnt  <= 0;
            m_res  <= '{0, 0, 0};
         end else if (bus.core_done) begin
            m_snap <= unpack(bus.core_out);
            m_res  <= argmax(unpack(bus.core_out));
            m_cnt  <= 1;
         end else if (m_cnt >= 1 && m_cnt < NC) begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", int'(bus.busy), (m_cnt >= 1 && m_cnt < NC) ? 1 : 0);
         chk("pred_valid", int'(bus.pred_valid), (m_cnt == NC) ? 1 : 0);
         chk("out", $signed(bus.out), m_out);
         chk("idx_err", int'(bus.idx_err), m_err);
         if (m_cnt == 0 || m_cnt == NC) begin
            chk("pred_class", int'(bus.pred_class), m_res.cls);
            chk("pred_score", $signed(bus.pred_score), m_res.score);
            chk("pred_margin", $signed(bus.pred_margin), m_res.margin);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input arr_t s);
      bus.core_out  = pack(s);
      bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_out"},    $signed(bus.out), 0);
      chk({nm, "_err"},    int'(bus.idx_err), 0);
      chk({nm, "_busy"},   int'(bus.busy), 0);
      chk({nm, "_valid"},  int'(bus.pred_valid), 0);
      chk({nm, "_class"},  int'(bus.pred_class), 0);
      chk({nm, "_score"},  $signed(bus.pred_score), 0);
      chk({nm, "_margin"}, $signed(bus.pred_margin), 0);
   endtask

   arr_t peak, tie, neg, rd, alt;

   initial begin
      bus.clear = 1'b0; bus.core_done = 1'b0; bus.core_out = '0; bus.out_idx = '0;
      peak = '{default: -100}; peak[7] = 300;
      tie  = '{default: 0};    tie[2] = 500; tie[5] = 500;
      for (int k = 0; k < NC; k++) neg[k] = -1024 + k;
      for (int k = 0; k < NC; k++) rd[k] = k * 10;
      rd[3] = -42;
      alt  = '{default: 0};    alt[1] = 200;

      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      tick();

      // single peak
      capture(peak);
      chk("peak_busy_c1", int'(bus.busy), 1);
      repeat (8) tick();
      chk("peak_busy_c9", int'(bus.busy), 1);
      chk("peak_valid_c9", int'(bus.pred_valid), 0);
      tick();
      chk("peak_busy_c10", int'(bus.busy), 0);
      chk("peak_valid_c10", int'(bus.pred_valid), 1);
      chk("peak_class", int'(bus.pred_class), 7);
      chk("peak_score", $signed(bus.pred_score), 300);
      chk("peak_margin", $signed(bus.pred_margin), MEN ? 400 : 0);

      // tie: lowest index wins
      capture(tie);
      repeat (9) tick();
      chk("tie_valid", int'(bus.pred_valid), 1);
      chk("tie_class", int'(bus.pred_class), 2);
      chk("tie_margin", $signed(bus.pred_margin), 0);

      // all negative
      capture(neg);
      repeat (9) tick();
      chk("neg_class", int'(bus.pred_class), 9);
      chk("neg_score", $signed(bus.pred_score), -1015);
      chk("neg_margin", $signed(bus.pred_margin), MEN ? 1 : 0);

      // readout and out-of-range index
      capture(rd);
      repeat (9) tick();
      bus.out_idx = 4'd3;
      tick();
      chk("rd_out3", $signed(bus.out), -42);
      chk("rd_err3", int'(bus.idx_err), 0);
      bus.out_idx = 4'd12;
      tick();
      chk("rd_out12", $signed(bus.out), 0);
      chk("rd_err12", int'(bus.idx_err), 1);
      bus.out_idx = 4'd7;

      // restart mid-scan: second capture in cycle 4
      capture(peak);
      repeat (3) tick();
      capture(alt);
      repeat (8) tick();
      chk("rst_valid_c13", int'(bus.pred_valid), 0);
      tick();
      chk("rst_valid_c14", int'(bus.pred_valid), 1);
      chk("rst_class_c14", int'(bus.pred_class), 1);
      chk("rst_score_c14", $signed(bus.pred_score), 200);

      // asynchronous reset in cycle 5 of a scan
      capture(peak);
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("post_rst_busy", int'(bus.busy), 0);
      chk("post_rst_valid", int'(bus.pred_valid), 0);
      capture(tie);
      repeat (9) tick();
      chk("post_rst_class", int'(bus.pred_class), 2);
      chk("post_rst_valid2", int'(bus.pred_valid), 1);

      // clear wins over a simultaneous capture
      bus.core_out  = pack(peak);
      bus.core_done = 1'b1;
      bus.clear     = 1'b1;
      tick();
      bus.core_done = 1'b0;
      bus.clear     = 1'b0;
      chk("clr_busy", int'(bus.busy), 0);
      chk("clr_valid", int'(bus.pred_valid), 0);
      chk("clr_class", int'(bus.pred_class), 0);
      chk("clr_score", $signed(bus.pred_score), 0);
      tick();
      chk("clr_busy_next", int'(bus.busy), 0);
      chk("clr_out_snap0", $signed(bus.out), 0);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dnn_result_readout.md
# dnn_result_readout

Parametrised result capture and classification stage placed after the `dnn_sigmoid_fix*` inference core in a top-level wrapper. On the core's completion pulse it snapshots all class scores and runs a sequential signed argmax, one class per cycle, to produce a predicted class. It also provides a registered, indexed score readout with out-of-range detection. This replaces a purely combinational output mux, and supports any score width and class count.

## Interface
- `DATA_WIDTH`, 11, signed fixed-point score width.
- `NUM_CLASSES`, 10, number of class scores; must be ≥ 2.
- `IDX_WIDTH`, 4, width of class indices; must satisfy 2^IDX_WIDTH ≥ NUM_CLASSES.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous soft clear.
- `core_done` in 1: single-cycle pulse from the inference core; `core_out` is valid in that cycle.
- `core_out` in NUM_CLASSES*DATA_WIDTH: flattened signed scores; class k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `out_idx` in IDX_WIDTH: readout index.
- `out` out DATA_WIDTH: signed snapshot score for the registered `out_idx`.
- `idx_err` out 1: high when the registered `out_idx` ≥ NUM_CLASSES.
- `busy` out 1: high while in SCAN.
- `pred_valid` out 1: argmax result is valid.
- `pred_class` out IDX_WIDTH: index of the maximum score.
- `pred_score` out DATA_WIDTH: the maximum score.
- `pred_margin` out DATA_WIDTH+1: best score minus second-best score (see Configuration).

## Operation
- States: IDLE, SCAN, DONE.
- **Capture.** When `core_done` is sampled high in any state, all scores load into the snapshot.
  - Best is initialised to snapshot[0] and best index to 0.
  - The scan index is set to 1, `pred_valid` is cleared, and the FSM goes to SCAN.
  - A `core_done` during SCAN aborts the current scan and restarts from the new data.
- **SCAN.** Each cycle compares snapshot[scan_idx] against best.
  - The comparison is signed and strict (`>`), so on a tie the lowest index wins.
  - After comparing index NUM_CLASSES-1, the FSM goes to DONE.
- **DONE.** `pred_valid` is held at 1 and the pred outputs are held until the next `core_done`, `clear` or `rst`.
- **`clear`.** Goes to IDLE. Clears the snapshot, `pred_valid`, `pred_class`, `pred_score` and `pred_margin` to 0. If `clear` and `core_done` are high in the same cycle, `clear` wins and the capture is dropped.
- **Readout.**
  - `out` is registered as snapshot[out_idx].
  - When `out_idx` ≥ NUM_CLASSES, `out` is 0 and `idx_err` is 1.
  - Readout is available in every state.
  - During SCAN, readout reflects the new snapshot.
- **Arithmetic.**
  - All compares are full-width signed.
  - The margin is computed sign-extended to DATA_WIDTH+1 bits, so it cannot overflow.

## Timing
- **Reset values.** On `rst`:
  - state = IDLE and the snapshot = 0.
  - `out`, `idx_err`, `busy`, `pred_valid`, `pred_class`, `pred_score` and `pred_margin` are all 0.
- **Snapshot timing.** With `core_done` high in cycle 0, the snapshot is visible from cycle 1.
- **Scan timing.**
  - `busy` is high in cycles 1 to NUM_CLASSES-1.
  - `pred_valid` is high from cycle NUM_CLASSES; for NUM_CLASSES=10, that is cycle 10.
- **Readout latency.** 1 cycle: `out_idx` applied in cycle n gives `out`/`idx_err` in cycle n+1.
- **Readout across capture.** An `out_idx` sampled in the same cycle as `core_done` returns the old snapshot value; from cycle 1 onward it returns the new value.
- **Reset during scan.** Asserting `rst` mid-scan returns all outputs to their reset values immediately, with no clock edge needed. After deassertion the block waits in IDLE.

## Configuration
- Macro: `DNN_READOUT_MARGIN_EN`.
- **Defined.**
  - Second-best score tracking is added to SCAN.
  - Second-best is initialised to the most negative value and updated on every compare: when a new best is found, the old best becomes second-best; otherwise a candidate greater than second-best replaces it.
  - `pred_margin` = best − second-best, valid with `pred_valid`.
- **Undefined.** The tracking logic is removed and `pred_margin` is tied to 0.

## Test plan
All scenarios use NUM_CLASSES=10 and DATA_WIDTH=11.
- **Single peak.** Class 7 = 300, all others = −100, `core_done` in cycle 0 → `busy` high in cycles 1–9; from cycle 10 `pred_valid`=1, `pred_class`=7, `pred_score`=300; `pred_margin`=400 (MARGIN_EN defined).
- **Tie.** Classes 2 and 5 = 500, others = 0 → `pred_class`=2; `pred_margin`=0 (MARGIN_EN defined).
- **All negative.** Score k = −1024+k → `pred_class`=9, `pred_score`=−1015.
- **Readout.** `out_idx`=3 with score 3 = −42 → `out`=−42 next cycle, `idx_err`=0. `out_idx`=12 → `out`=0, `idx_err`=1 next cycle.
- **Restart mid-scan.** A second `core_done` in cycle 4 carrying class 1 = 200 → `pred_valid` stays low until cycle 14, then `pred_class`=1.
- **Reset and clear.**
  - `rst` pulsed in cycle 5 mid-scan → all outputs are 0 asynchronously; a later `core_done` is processed normally.
  - `clear` together with `core_done` → the FSM stays in IDLE and `pred_valid`=0.
